// File: rtl/tinyriscv_pkg.sv
// Shared types and constants for the tightly-coupled memory block.
package tinyriscv_pkg;

    // Controller state: INIT while the array is being prepared, READY for traffic.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } tcm_state_e;

    // Width of the byte address presented by the master.
    localparam int unsigned TcmAddrW = 32;

endpackage

// File: rtl/tcm_sram_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module tcm_sram_array #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 4096,
  parameter              MemInitFile = ""
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic                       re_i,
  input  logic [DataWidth/8-1:0]     be_i,
  input  logic [$clog2(Depth)-1:0]   idx_i,
  input  logic [DataWidth-1:0]       wdata_i,
  output logic [DataWidth-1:0]       rdata_o
);

  localparam int unsigned NumBytes = DataWidth / 8;

  (* ram_style = "block" *) logic [DataWidth-1:0] mem [Depth];

  // Byte-masked write and registered read; the controller never issues both in one cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (be_i[k]) begin
          mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/tcm_sram.sv
// TCM front end: zero-fill sequencer, request grant, range check and response registers.
// Handshake: a request is accepted on a rising edge when req_i and gnt_o are both high;
// exactly one cycle later rvalid_o pulses for one cycle with rdata_o/err_o, which then
// hold their value until the next response. Responses cannot be back-pressured.
module tcm_sram
    import tinyriscv_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 4096,
    parameter bit          ZeroInit    = 1'b1,
    parameter              MemInitFile = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [TcmAddrW-1:0]    addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   init_done_o,
    output logic                   dbg_state_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned ByteOffW = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(Depth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

    tcm_state_e            state_q, state_d;
    logic [IdxW-1:0]       cnt_q, cnt_d;

    logic [TcmAddrW-1:0]   word_addr;
    logic                  in_range;
    logic [IdxW-1:0]       req_idx;
    logic                  fill;

    logic                  arr_we;
    logic                  arr_re;
    logic [NumBytes-1:0]   arr_be;
    logic [IdxW-1:0]       arr_idx;
    logic [DataWidth-1:0]  arr_wdata;
    logic [DataWidth-1:0]  arr_rdata;

    logic                  rvalid_q;
    logic                  err_q;
    logic                  rd_ok_q;

    // Byte offset is dropped; anything at or beyond Depth words is an error.
    assign word_addr = addr_i >> ByteOffW;
    assign in_range  = (word_addr < TcmAddrW'(Depth));
    assign req_idx   = addr_i[ByteOffW +: IdxW];

    assign init_done_o = (state_q == READY);
    assign dbg_state_o = state_q;
    assign gnt_o       = req_i & init_done_o;
    assign fill        = (state_q == INIT) && ZeroInit;

    // State register and zero-fill word counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every word once when zero-filling, otherwise go straight to READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (ZeroInit) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Array port steering: the fill sweep owns the port in INIT, granted traffic in READY.
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_be    = be_i;
        arr_idx   = req_idx;
        arr_wdata = wdata_i;
        if (fill) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_idx   = cnt_q;
            arr_wdata = '0;
        end else if (gnt_o && in_range) begin
            arr_we = we_i;
            arr_re = ~we_i;
        end
    end

    tcm_sram_array #(
        .DataWidth  (DataWidth),
        .Depth      (Depth),
        .MemInitFile(MemInitFile)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .be_i   (arr_be),
        .idx_i  (arr_idx),
        .wdata_i(arr_wdata),
        .rdata_o(arr_rdata)
    );

    // Response tracking: valid pulses one cycle after grant; error/read-kind update only on grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            rvalid_q <= gnt_o;
            if (gnt_o) begin
                err_q   <= ~in_range;
                rd_ok_q <= ~we_i & in_range;
            end
        end
    end

    // Read data comes from the array register only for in-range reads; writes and errors return zero.
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rd_ok_q ? arr_rdata : '0;

endmodule
